// File: rtl/gain_interp.sv
// Band-to-bin gain interpolator: loads NB_BANDS Q1.15 band gains, then streams
// NB_BINS linearly interpolated bin gains. Optional macro: GAIN_INTERP_SMOOTH_EN.
module gain_interp #(
   parameter int unsigned NB_BANDS = 22,
   parameter int unsigned NB_BINS  = 481
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [15:0] in_gain,
   output logic        in_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_gain,
   output logic [8:0]  out_bin,
   output logic        out_last
);

   localparam int unsigned   BW              = $clog2(NB_BANDS);
   localparam logic [8:0]    LAST_INTERP_BIN = 9'd399;
   localparam logic [8:0]    LAST_BIN        = 9'(NB_BINS - 1);
   localparam logic [BW-1:0] LAST_BEAT       = BW'(NB_BANDS - 1);

   typedef enum logic [1:0] {LOAD, INTERP, ZERO} state_t;

   state_t                r_state;
   state_t                w_next;
   logic [15:0]           r_g [NB_BANDS];
   logic [BW-1:0]         r_beat;
   logic [BW-1:0]         r_band;
   logic [BW-1:0]         w_band_nx;
   logic [6:0]            r_j;
   logic [6:0]            w_size;
   logic [15:0]           w_recip;
   logic [8:0]            r_bin;
   logic [15:0]           w_gain_in;
   logic                  w_in_fire;
   logic                  w_out_fire;
   logic [15:0]           w_g0;
   logic [15:0]           w_g1;
   logic [15:0]           w_frac;
   logic signed [16:0]    w_d;
   logic signed [33:0]    w_prod;
   logic signed [33:0]    w_sum;

   assign in_ready   = (r_state == LOAD);
   assign out_valid  = (r_state != LOAD);
   assign out_bin    = r_bin;
   assign out_last   = out_valid && (r_bin == LAST_BIN);
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = out_valid && out_ready;
   assign w_band_nx  = r_band + 1'b1;

   // Band size S_i (bins) and floor(65536/S_i), grouped by equal band width
   always_comb begin
      w_size  = 7'd88;
      w_recip = 16'd744;
      if (r_band < BW'(8)) begin
         w_size  = 7'd4;
         w_recip = 16'd16384;
      end else if (r_band < BW'(12)) begin
         w_size  = 7'd8;
         w_recip = 16'd8192;
      end else if (r_band < BW'(15)) begin
         w_size  = 7'd16;
         w_recip = 16'd4096;
      end else if (r_band < BW'(17)) begin
         w_size  = 7'd24;
         w_recip = 16'd2730;
      end else if (r_band == BW'(17)) begin
         w_size  = 7'd32;
         w_recip = 16'd2048;
      end else if (r_band == BW'(18)) begin
         w_size  = 7'd48;
         w_recip = 16'd1365;
      end else if (r_band == BW'(19)) begin
         w_size  = 7'd72;
         w_recip = 16'd910;
      end
   end

   // Output gain is combinational from held counters, so it stays stable under backpressure
   always_comb begin
      w_g0     = r_g[r_band];
      w_g1     = r_g[w_band_nx];
      w_frac   = {9'b0, r_j} * w_recip;
      w_d      = $signed({1'b0, w_g1}) - $signed({1'b0, w_g0});
      w_prod   = w_d * $signed({1'b0, w_frac});
      w_sum    = (w_prod >>> 16) + $signed({18'b0, w_g0});
      out_gain = (r_state == INTERP) ? 16'(w_sum) : '0;
   end

`ifdef GAIN_INTERP_SMOOTH_EN
   logic [15:0] r_lastg [NB_BANDS];
   logic [31:0] w_decay_p;
   logic [15:0] w_decay;

   assign w_decay_p = {16'b0, r_lastg[r_beat]} * 32'd19661;
   assign w_decay   = 16'(w_decay_p >> 15);
   assign w_gain_in = (in_gain > w_decay) ? in_gain : w_decay;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < NB_BANDS; k++) r_lastg[k] <= '0;
      end else if (w_in_fire) begin
         r_lastg[r_beat] <= w_gain_in;
      end
   end
`else
   assign w_gain_in = in_gain;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= LOAD;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         LOAD:    if (w_in_fire && r_beat == LAST_BEAT)         w_next = INTERP;
         INTERP:  if (w_out_fire && r_bin == LAST_INTERP_BIN)   w_next = ZERO;
         ZERO:    if (w_out_fire && r_bin == LAST_BIN)          w_next = LOAD;
         default: w_next = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beat <= '0;
         for (int unsigned k = 0; k < NB_BANDS; k++) r_g[k] <= '0;
      end else if (w_in_fire) begin
         r_g[r_beat] <= w_gain_in;
         r_beat      <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin  <= '0;
         r_band <= '0;
         r_j    <= '0;
      end else if (w_out_fire) begin
         if (r_state == INTERP) begin
            r_bin <= r_bin + 1'b1;
            if (r_bin == LAST_INTERP_BIN) begin
               r_band <= '0;
               r_j    <= '0;
            end else if (r_j == w_size - 7'd1) begin
               r_band <= w_band_nx;
               r_j    <= '0;
            end else begin
               r_j <= r_j + 1'b1;
            end
         end else begin
            r_bin <= (r_bin == LAST_BIN) ? '0 : r_bin + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_gain_interp.sv
// Directed self-checking bench for gain_interp; honours GAIN_INTERP_SMOOTH_EN.
module tb_gain_interp;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_gain;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_gain;
   logic [8:0]  out_bin;
   logic        out_last;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] frame [22];
   logic [15:0] got   [481];

   gain_interp #(.NB_BANDS(22), .NB_BINS(481)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_gain   (in_gain),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_gain  (out_gain),
      .out_bin   (out_bin),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame();
      for (int k = 0; k < 22; k++) begin
         int wait_cyc;
         in_valid = 1'b1;
         in_gain  = frame[k];
         wait_cyc = 0;
         while (!in_ready && wait_cyc < 100) begin
            tick();
            wait_cyc++;
         end
         tick();
      end
      in_valid = 1'b0;
      check_eq("first_valid", 32'(out_valid), 1);
      check_eq("first_bin", 32'(out_bin), 0);
   endtask

   task automatic recv_frame(input int stall_bin);
      int   exp_bin;
      int   beats;
      int   cyc;
      int   seq_err;
      int   last_err;
      logic stalled;
      logic [15:0] held;
      exp_bin  = 0;
      beats    = 0;
      cyc      = 0;
      seq_err  = 0;
      last_err = 0;
      stalled  = 1'b0;
      for (int i = 0; i < 481; i++) got[i] = 16'hDEAD;
      out_ready = 1'b1;
      while (beats < 481 && cyc < 2000) begin
         if (out_valid && int'(out_bin) == stall_bin && !stalled) begin
            held      = out_gain;
            out_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               tick();
               check_eq("stall_valid", 32'(out_valid), 1);
               check_eq("stall_bin", 32'(out_bin), 32'(stall_bin));
               check_eq("stall_gain", 32'(out_gain), 32'(held));
            end
            stalled   = 1'b1;
            out_ready = 1'b1;
         end
         if (out_valid && out_ready) begin
            if (int'(out_bin) != exp_bin) seq_err++;
            if (out_last != (exp_bin == 480)) last_err++;
            if (out_bin < 9'd481) got[out_bin] = out_gain;
            exp_bin++;
            beats++;
         end
         tick();
         cyc++;
      end
      check_eq("beats", 32'(beats), 481);
      check_eq("bin_seq_err", 32'(seq_err), 0);
      check_eq("last_err", 32'(last_err), 0);
      if (stall_bin >= 0) check_eq("stall_seen", 32'(stalled), 1);
      check_eq("end_out_valid", 32'(out_valid), 0);
      check_eq("end_in_ready", 32'(in_ready), 1);
   endtask

   initial begin
      int bad_hi;
      int bad_lo;
      int cyc;
      logic [15:0] exp_flat;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_gain   = '0;
      out_ready = 1'b0;
      tick();
      tick();
      check_eq("rst_out_valid", 32'(out_valid), 0);
      check_eq("rst_in_ready", 32'(in_ready), 1);
      check_eq("rst_out_gain", 32'(out_gain), 0);
      check_eq("rst_out_bin", 32'(out_bin), 0);
      check_eq("rst_out_last", 32'(out_last), 0);
      rst_n = 1'b1;
      tick();

      // Interpolation values plus backpressure on bin 10
      frame[0] = 16'd0;
      frame[1] = 16'd16384;
      frame[2] = 16'd16383;
      for (int k = 3; k < 20; k++) frame[k] = 16'd16384;
      frame[20] = 16'd32768;
      frame[21] = 16'd0;
      send_frame();
      recv_frame(10);
      check_eq("bin0", 32'(got[0]), 0);
      check_eq("bin1", 32'(got[1]), 4096);
      check_eq("bin2", 32'(got[2]), 8192);
      check_eq("bin3", 32'(got[3]), 12288);
      check_eq("bin4", 32'(got[4]), 16384);
      check_eq("bin5_floor", 32'(got[5]), 16383);
      check_eq("bin9", 32'(got[9]), 16383);
      check_eq("bin10", 32'(got[10]), 16383);
      check_eq("bin11", 32'(got[11]), 16383);
      check_eq("bin276", 32'(got[276]), 24574);
      check_eq("bin356", 32'(got[356]), 16400);
      check_eq("bin399", 32'(got[399]), 404);
      check_eq("bin400", 32'(got[400]), 0);
      check_eq("bin480", 32'(got[480]), 0);

      // Reset while bin 200 is presented
      for (int k = 0; k < 22; k++) frame[k] = 16'd32768;
      send_frame();
      out_ready = 1'b1;
      cyc = 0;
      while (!(out_valid && out_bin == 9'd200) && cyc < 1000) begin
         tick();
         cyc++;
      end
      check_eq("reach_bin200", 32'(out_bin), 200);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_out_valid", 32'(out_valid), 0);
      check_eq("midrst_in_ready", 32'(in_ready), 1);
      check_eq("midrst_out_bin", 32'(out_bin), 0);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b0;
      tick();

      // Full-scale frame after reset
      send_frame();
      recv_frame(-1);
      bad_hi = 0;
      bad_lo = 0;
      for (int i = 0; i < 400; i++) if (got[i] != 16'd32768) bad_hi++;
      for (int i = 400; i < 481; i++) if (got[i] != 16'd0) bad_lo++;
      check_eq("full_bins_lo400", 32'(bad_hi), 0);
      check_eq("full_bins_zero", 32'(bad_lo), 0);

      // Zero frame after full-scale frame
      for (int k = 0; k < 22; k++) frame[k] = 16'd0;
`ifdef GAIN_INTERP_SMOOTH_EN
      exp_flat = 16'd19661;
`else
      exp_flat = 16'd0;
`endif
      send_frame();
      recv_frame(-1);
      bad_hi = 0;
      bad_lo = 0;
      for (int i = 0; i < 400; i++) if (got[i] != exp_flat) bad_hi++;
      for (int i = 400; i < 481; i++) if (got[i] != 16'd0) bad_lo++;
      check_eq("zero_frame_bins", 32'(bad_hi), 0);
      check_eq("zero_frame_tail", 32'(bad_lo), 0);
      check_eq("zero_frame_bin0", 32'(got[0]), 32'(exp_flat));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
